// File: rtl/output_drain_ctrl_pkg.sv
// Shared types for the output drain controller: FSM state encoding and the
// result-entry record stored in the drain FIFO.
package output_drain_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_COORD_WIDTH = 32;

    // Entry record at the default widths; storage packs fields in this order.
    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0]  data;
        logic [DEF_COORD_WIDTH-1:0] x;
        logic [DEF_COORD_WIDTH-1:0] y;
        logic [DEF_COORD_WIDTH-1:0] ch;
    } entry_t;

    // Width of one packed entry {data, x, y, ch}.
    function automatic int entry_width(input int dw, input int cw);
        return dw + 3 * cw;
    endfunction

endpackage

// File: rtl/output_drain_ctrl_sync_fifo_mem.sv
// Drain FIFO storage: one synchronous write port and an asynchronous read of
// the head so the controller can present first-word-fall-through data.
// Storage is intentionally not reset.
module sync_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 112,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the pushed entry into its slot.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/output_drain_ctrl.sv
// Output drain controller: buffers datapath results tagged with coordinates,
// presents them to the host in push order, back-pressures the sequencer when
// nearly full and pulses done once the final result of a layer has drained.
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | accepting results until the in_last entry is pushed
// DRAIN  | no more input; emptying the FIFO to the host
// DONE   | one-cycle done pulse, then back to IDLE
module output_drain_ctrl
    import output_drain_ctrl_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int COORD_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   arst_n_in,
    input  logic                   start,
    output logic                   busy,
    input  logic                   in_valid,
    input  logic                   in_last,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [COORD_WIDTH-1:0] in_x,
    input  logic [COORD_WIDTH-1:0] in_y,
    input  logic [COORD_WIDTH-1:0] in_ch,
    output logic                   stall,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [COORD_WIDTH-1:0] out_x,
    output logic [COORD_WIDTH-1:0] out_y,
    output logic [COORD_WIDTH-1:0] out_ch,
    output logic                   done,
    output logic                   overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = entry_width(DATA_WIDTH, COORD_WIDTH);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_STALL = CNT_W'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic             in_stream;
    logic             push;
    logic             pop;
    logic             drop;
    logic [ENT_W-1:0] wr_entry;
    logic [ENT_W-1:0] rd_entry;

    assign in_stream = (state_q == ST_STREAM);
    assign out_valid = (count_q != '0) && (state_q == ST_STREAM || state_q == ST_DRAIN);
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a push at full is still legal.
    assign push      = in_stream && in_valid && ((count_q < CNT_FULL) || pop);
    assign drop      = in_stream && in_valid && (count_q == CNT_FULL) && !pop;

    // Raised one entry early so the result already in flight still fits.
    assign stall     = in_stream && (count_q >= CNT_STALL);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign overflow  = overflow_q;

    assign wr_entry = {in_data, in_x, in_y, in_ch};
    assign {out_data, out_x, out_y, out_ch} = rd_entry;

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_entry)
    );

    // Next-state, pointer, occupancy and sticky-error computation.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_STREAM;
                    overflow_d = 1'b0;
                end
            end
            ST_STREAM: begin
                if (push && in_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register controller state; reset discards all held entries.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_output_drain_ctrl.sv
// Scoreboard bench for output_drain_ctrl: stimulus pushes expected entries,
// a negedge monitor pops and compares whenever the host accepts an entry.
module tb_output_drain_ctrl;
    import output_drain_ctrl_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int CW    = 32;

    logic          clk = 1'b0;
    logic          arst_n_in = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_x = '0;
    logic [CW-1:0] in_y = '0;
    logic [CW-1:0] in_ch = '0;
    logic          stall;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_x;
    logic [CW-1:0] out_y;
    logic [CW-1:0] out_ch;
    logic          done;
    logic          overflow;

    int     checks = 0;
    int     failures = 0;
    int     done_cnt = 0;
    int     pop_cnt = 0;
    entry_t sb[$];
    entry_t mon_exp;
    entry_t mon_act;

    output_drain_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .COORD_WIDTH(CW)) dut (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .start     (start),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_ch     (in_ch),
        .stall     (stall),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_ch    (out_ch),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Monitor: count done pulses and check every accepted entry against the scoreboard.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (arst_n_in && out_valid && out_ready) begin
            checks++;
            mon_act = {out_data, out_x, out_y, out_ch};
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected actual=%h required=no_entry", mon_act);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_act !== mon_exp) begin
                    failures++;
                    $display("FAIL pop_entry actual=%h required=%h", mon_act, mon_exp);
                end
            end
            pop_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one result for a cycle; accepted entries go to the scoreboard.
    task automatic push_one(input logic [DW-1:0] d, input logic [CW-1:0] x,
                            input logic [CW-1:0] y, input logic [CW-1:0] c,
                            input bit last, input bit accept);
        entry_t e;
        in_valid = 1'b1;
        in_last  = last;
        in_data  = d;
        in_x     = x;
        in_y     = y;
        in_ch    = c;
        e.data = d; e.x = x; e.y = y; e.ch = c;
        if (accept) sb.push_back(e);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Wait (bounded) for the done pulse; the scoreboard must be empty by then.
    task automatic wait_done(input string name, input int max_cyc, input bit rnd);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (done) seen = 1'b1;
        end
        chk({name, "_done_seen"}, 64'(seen), 64'd1);
        chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
        out_ready = 1'b0;
        tick();
        chk({name, "_idle_after"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        int p0;
        int d0;
        int n;
        int guard;

        // Reset state
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        tick();
        arst_n_in = 1'b1;
        tick();

        // Single result, FWFT latency and done pulse
        out_ready = 1'b1;
        pulse_start();
        chk("t1_busy", 64'(busy), 64'd1);
        push_one(16'h0012, 32'd3, 32'd4, 32'd5, 1'b1, 1'b1);
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_data", 64'(out_data), 64'h12);
        tick();
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);
        tick();
        chk("t1_done_low", 64'(done), 64'd0);
        chk("t1_busy_low", 64'(busy), 64'd0);

        // Back-pressure, overflow on 5th push, concurrent push/pop at full
        out_ready = 1'b0;
        p0 = pop_cnt;
        pulse_start();
        push_one(16'h0100, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("t2_stall_c1", 64'(stall), 64'd0);
        push_one(16'h0101, 32'd2, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("t2_stall_c2", 64'(stall), 64'd0);
        push_one(16'h0102, 32'd3, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("t2_stall_c3", 64'(stall), 64'd1);
        push_one(16'h0103, 32'd4, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("t2_overflow_c4", 64'(overflow), 64'd0);
        push_one(16'h0bad, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("t2_overflow_set", 64'(overflow), 64'd1);
        chk("t2_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        push_one(16'h0104, 32'd6, 32'd0, 32'd0, 1'b1, 1'b1);
        chk("t2_overflow_sticky", 64'(overflow), 64'd1);
        chk("t2_stall_drain", 64'(stall), 64'd0);
        wait_done("t2", 20, 1'b0);
        chk("t2_pops", 64'(pop_cnt - p0), 64'd5);

        // Full with concurrent pop, no overflow
        p0 = pop_cnt;
        pulse_start();
        chk("t3_overflow_cleared", 64'(overflow), 64'd0);
        for (int i = 0; i < DEPTH; i++)
            push_one(16'h0200 + 16'(i), 32'(i), 32'd7, 32'd9, 1'b0, 1'b1);
        out_ready = 1'b1;
        push_one(16'h02ff, 32'd99, 32'd7, 32'd9, 1'b1, 1'b1);
        chk("t3_overflow", 64'(overflow), 64'd0);
        chk("t3_out_valid", 64'(out_valid), 64'd1);
        wait_done("t3", 20, 1'b0);
        chk("t3_pops", 64'(pop_cnt - p0), 64'd5);

        // Wrap: ten entries with random host readiness
        p0 = pop_cnt;
        pulse_start();
        n = 0;
        guard = 0;
        while (n < 10 && guard < 400) begin
            out_ready = 1'($urandom_range(0, 1));
            if (!stall) begin
                push_one(16'(n), 32'(n), 32'(n + 1), 32'(n + 2), n == 9, 1'b1);
                n++;
            end else begin
                tick();
            end
            guard++;
        end
        chk("t4_pushed", 64'(n), 64'd10);
        wait_done("t4", 400, 1'b1);
        chk("t4_pops", 64'(pop_cnt - p0), 64'd10);

        // Reset mid-DRAIN with two entries held
        out_ready = 1'b0;
        pulse_start();
        push_one(16'h0300, 32'd1, 32'd1, 32'd1, 1'b0, 1'b1);
        push_one(16'h0301, 32'd2, 32'd2, 32'd2, 1'b1, 1'b1);
        chk("t5_held", 64'(out_valid), 64'd1);
        d0 = done_cnt;
        arst_n_in = 1'b0;
        #1;
        chk("t5_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        sb.delete();
        tick();
        tick();
        arst_n_in = 1'b1;
        tick();
        tick();
        tick();
        chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t5_out_valid_idle", 64'(out_valid), 64'd0);
        p0 = pop_cnt;
        out_ready = 1'b1;
        pulse_start();
        push_one(16'h0399, 32'd8, 32'd8, 32'd8, 1'b1, 1'b1);
        wait_done("t5", 20, 1'b0);
        chk("t5_pops", 64'(pop_cnt - p0), 64'd1);

        // in_valid in IDLE and start during STREAM are ignored
        out_ready = 1'b0;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("t6_idle_out_valid", 64'(out_valid), 64'd0);
        chk("t6_idle_busy", 64'(busy), 64'd0);
        p0 = pop_cnt;
        pulse_start();
        for (int i = 0; i < DEPTH; i++)
            push_one(16'h0400 + 16'(i), 32'd0, 32'(i), 32'd1, 1'b0, 1'b1);
        push_one(16'h0bad, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        pulse_start();
        chk("t6_overflow_kept", 64'(overflow), 64'd1);
        chk("t6_busy", 64'(busy), 64'd1);
        chk("t6_stall", 64'(stall), 64'd1);
        out_ready = 1'b1;
        push_one(16'h04ff, 32'd1, 32'd1, 32'd1, 1'b1, 1'b1);
        wait_done("t6", 20, 1'b0);
        chk("t6_pops", 64'(pop_cnt - p0), 64'd5);
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("t6_idle_overflow", 64'(overflow), 64'd1);
        chk("t6_idle_out_valid2", 64'(out_valid), 64'd0);
        pulse_start();
        chk("t6_start_clears", 64'(overflow), 64'd0);
        push_one(16'h0500, 32'd2, 32'd2, 32'd2, 1'b1, 1'b1);
        wait_done("t6b", 20, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
